// File: rtl/regfile_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_pkg : shared types and helpers for the register_file scan reader
// Rev 1.0
// ---------------------------------------------------------------------------
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int BUF_DEPTH = 2;

  // Depth need not be a power of two, so wrap explicitly at depth-1.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input int unsigned depth);
    return (addr >= depth - 32'd1) ? 32'd0 : addr + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_out_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// scan_out_buf : 2-entry valid/ready FIFO; head word is always presented
// Rev 1.0
// ---------------------------------------------------------------------------
module scan_out_buf
  import regfile_pkg::*;
#(
  parameter int WIDTH = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o    = (cnt_q == 2'(BUF_DEPTH));
  assign empty_o   = (cnt_q == 2'd0);
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);
  assign data_o    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (w_do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (w_do_pop) rd_ptr_q <= !rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_scan_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_scan_reader : sweeps a wrapping register_file address range and
// streams the words on a valid/ready port with address and last flag
// Rev 1.0
// ---------------------------------------------------------------------------
module regfile_scan_reader
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [ADDR_WIDTH:0]   count_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic                  m_last_o
);

  localparam int                WORD_W  = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] c_one   = (ADDR_WIDTH + 1)'(1);

  state_e                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [ADDR_WIDTH-1:0] rd_addr_d;
  logic [ADDR_WIDTH:0]   rem_q;

  logic                  w_pop;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pend;
  logic                  w_full;
  logic                  w_empty;
  logic [1:0]            w_occ;
  logic [WORD_W-1:0]     w_push_word;
  logic [WORD_W-1:0]     w_head;

  // Credit counts a word leaving this cycle, so 1 beat/cycle holds at latency 1.
  assign w_pop     = !w_empty && m_ready_i;
  assign w_occ     = (w_full ? 2'd2 : {1'b0, !w_empty}) - {1'b0, w_pop} + {1'b0, w_pend};
  assign w_issue   = (state_q == RUN) && (rem_q != '0) && (w_occ < 2'd2);
  assign rd_addr_d = ADDR_WIDTH'(next_addr(32'(rd_addr_q), DEPTH));

  if (RD_LATENCY == 0) begin : g_lat0
    assign w_pend      = 1'b0;
    assign w_push      = w_issue;
    assign w_push_word = {rd_data_i, rd_addr_q, rem_q == c_one};
  end else begin : g_lat1
    logic                  pend_q;
    logic                  pend_last_q;
    logic [ADDR_WIDTH-1:0] pend_addr_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend_q      <= 1'b0;
        pend_last_q <= 1'b0;
        pend_addr_q <= '0;
      end else begin
        pend_q      <= w_issue;
        pend_last_q <= (rem_q == c_one);
        pend_addr_q <= rd_addr_q;
      end
    end

    assign w_pend      = pend_q;
    assign w_push      = pend_q;
    assign w_push_word = {rd_data_i, pend_addr_q, pend_last_q};
  end

  scan_out_buf #(
    .WIDTH (WORD_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .data_i  (w_push_word),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_addr_q <= '0;
      rem_q     <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (({1'b0, start_addr_i} >= c_depth) || (count_i > c_depth)) begin
              err_q <= 1'b1;
            end else if (count_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q   <= RUN;
              busy_q    <= 1'b1;
              rd_addr_q <= start_addr_i;
              rem_q     <= count_i;
            end
          end
        end
        RUN: begin
          if (w_issue) begin
            rem_q <= rem_q - c_one;
            if (rem_q == c_one) state_q <= DRAIN;
            else                rd_addr_q <= rd_addr_d;
          end
        end
        DRAIN: begin
          if (w_pop && w_head[0]) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rd_addr_o = rd_addr_q;
  assign m_valid_o = !w_empty;
  assign m_data_o  = w_head[WORD_W-1 -: DATA_WIDTH];
  assign m_addr_o  = w_head[ADDR_WIDTH:1];
  assign m_last_o  = w_head[0] && !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scan_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_regfile_scan_reader : scoreboard bench, DUT A (DEPTH 16, latency 1) and
// DUT B (DEPTH 12, latency 0); Rev 1.0
// ---------------------------------------------------------------------------
module tb_regfile_scan_reader;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  addr;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_start = 1'b0;
  logic [3:0]  a_saddr = 4'd0;
  logic [4:0]  a_cnt   = 5'd0;
  logic        a_ready = 1'b1;
  logic        a_busy, a_done, a_err, a_valid, a_last;
  logic [3:0]  a_rd_addr, a_maddr;
  logic [15:0] a_rd_data, a_mdata;

  logic        b_start = 1'b0;
  logic [3:0]  b_saddr = 4'd0;
  logic [4:0]  b_cnt   = 5'd0;
  logic        b_ready = 1'b1;
  logic        b_busy, b_done, b_err, b_valid, b_last;
  logic [3:0]  b_rd_addr, b_maddr;
  logic [15:0] b_rd_data, b_mdata;

  beat_t qa[$];
  beat_t qb[$];
  int    n_cmp  = 0;
  int    n_bad  = 0;
  int    a_beats = 0;
  int    a_errs  = 0;
  logic        a_stall = 1'b0;
  logic [20:0] a_prev  = '0;
  bit          bp      = 1'b0;
  bit [9:0]    bp_pat  = 10'b1001000100;
  int          bp_ph   = 0;

  function automatic logic [15:0] memv(input logic [3:0] a);
    return 16'(16'h1111 * {12'd0, a});
  endfunction

  always @(posedge clk) a_rd_data <= memv(a_rd_addr);
  assign b_rd_data = memv(b_rd_addr);

  regfile_scan_reader #(
    .DATA_WIDTH (16), .DEPTH (16), .ADDR_WIDTH (4), .RD_LATENCY (1)
  ) dut_a (
    .clk (clk), .rst (rst), .start_i (a_start), .start_addr_i (a_saddr), .count_i (a_cnt),
    .busy_o (a_busy), .done_o (a_done), .err_o (a_err), .rd_addr_o (a_rd_addr),
    .rd_data_i (a_rd_data), .m_valid_o (a_valid), .m_ready_i (a_ready),
    .m_data_o (a_mdata), .m_addr_o (a_maddr), .m_last_o (a_last)
  );

  regfile_scan_reader #(
    .DATA_WIDTH (16), .DEPTH (12), .ADDR_WIDTH (4), .RD_LATENCY (0)
  ) dut_b (
    .clk (clk), .rst (rst), .start_i (b_start), .start_addr_i (b_saddr), .count_i (b_cnt),
    .busy_o (b_busy), .done_o (b_done), .err_o (b_err), .rd_addr_o (b_rd_addr),
    .rd_data_i (b_rd_data), .m_valid_o (b_valid), .m_ready_i (b_ready),
    .m_data_o (b_mdata), .m_addr_o (b_maddr), .m_last_o (b_last)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input bit to_b, input int sa, input int n, input int depth);
    int a = sa;
    for (int i = 0; i < n; i++) begin
      beat_t e;
      e.data = memv(4'(a));
      e.addr = 4'(a);
      e.last = (i == n - 1);
      if (to_b) qb.push_back(e);
      else      qa.push_back(e);
      a = (a + 1) % depth;
    end
  endtask

  task automatic start_a(input int sa, input int n, input bit exp);
    @(posedge clk); #1;
    a_start = 1'b1; a_saddr = 4'(sa); a_cnt = 5'(n);
    if (exp) push_exp(1'b0, sa, n, 16);
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic start_b(input int sa, input int n, input bit exp);
    @(posedge clk); #1;
    b_start = 1'b1; b_saddr = 4'(sa); b_cnt = 5'(n);
    if (exp) push_exp(1'b1, sa, n, 12);
    @(posedge clk); #1;
    b_start = 1'b0;
  endtask

  task automatic wait_done(input bit to_b, input int budget, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      seen = to_b ? b_done : a_done;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  // Scoreboard monitor for DUT A, with hold-while-stalled check
  always @(negedge clk) begin
    if (rst) begin
      a_stall <= 1'b0;
    end else begin
      if (a_stall)
        chk("a_stable", 32'({a_valid, a_mdata, a_maddr, a_last}), 32'({1'b1, a_prev}));
      if (a_valid && a_ready) begin
        if (qa.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL a_unexpected: beat addr %0d data 0x%0h, expected no beat", a_maddr, a_mdata);
        end else begin
          beat_t e;
          e = qa.pop_front();
          chk("a_beat", 32'({a_mdata, a_maddr, a_last}), 32'(e));
          a_beats <= a_beats + 1;
        end
      end
      a_stall <= a_valid && !a_ready;
      a_prev  <= {a_mdata, a_maddr, a_last};
      if (a_err) a_errs <= a_errs + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && b_valid && b_ready) begin
      if (qb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_unexpected: beat addr %0d data 0x%0h, expected no beat", b_maddr, b_mdata);
      end else begin
        beat_t e;
        e = qb.pop_front();
        chk("b_beat", 32'({b_mdata, b_maddr, b_last}), 32'(e));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp) begin
        a_ready = bp_pat[bp_ph];
        bp_ph   = (bp_ph + 1) % 10;
      end else begin
        a_ready = 1'b1;
      end
    end
  end

  initial begin
    int errs0, base;
    bit saw;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("a_reset_outs", 32'({a_busy, a_done, a_err, a_valid, a_last, a_rd_addr, a_mdata, a_maddr}), 32'd0);
    chk("b_reset_outs", 32'({b_busy, b_done, b_err, b_valid, b_last, b_rd_addr, b_mdata, b_maddr}), 32'd0);

    // Basic burst with exact latency and back-to-back beats
    start_a(2, 4, 1'b1);
    @(negedge clk);
    chk("a_lat_rd_addr", 32'(a_rd_addr), 32'd2);
    chk("a_lat_c1_valid", 32'(a_valid), 32'd0);
    @(negedge clk);
    chk("a_lat_c2_valid", 32'(a_valid), 32'd0);
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      chk("a_burst_valid", 32'(a_valid), 32'd1);
    end
    chk("a_burst_last", 32'(a_last), 32'd1);
    @(negedge clk);
    chk("a_done_busy", 32'({a_done, a_busy}), 32'b10);
    chk("a_basic_drained", 32'(qa.size()), 32'd0);

    start_a(14, 4, 1'b1);
    wait_done(1'b0, 30, "a_wrap_done");
    chk("a_wrap_drained", 32'(qa.size()), 32'd0);

    start_a(15, 16, 1'b1);
    wait_done(1'b0, 60, "a_full_done");

    // Backpressure plus an ignored start while busy
    errs0 = a_errs;
    bp = 1'b1;
    start_a(3, 8, 1'b1);
    repeat (5) @(posedge clk);
    start_a(0, 2, 1'b0);
    @(negedge clk);
    chk("a_busy_during", 32'(a_busy), 32'd1);
    wait_done(1'b0, 200, "a_bp_done");
    bp = 1'b0;
    chk("a_bp_no_err", 32'(a_errs - errs0), 32'd0);
    chk("a_bp_drained", 32'(qa.size()), 32'd0);

    start_a(5, 0, 1'b0);
    @(negedge clk);
    chk("a_cnt0_done", 32'({a_done, a_err, a_busy}), 32'b100);
    @(negedge clk);
    chk("a_cnt0_quiet", 32'({a_done, a_valid}), 32'd0);

    start_a(0, 17, 1'b0);
    @(negedge clk);
    chk("a_cnt17_err", 32'({a_err, a_done, a_busy}), 32'b100);
    @(negedge clk);
    chk("a_cnt17_pulse", 32'({a_err, a_busy}), 32'd0);

    // Asynchronous reset in the middle of a burst
    start_a(0, 6, 1'b1);
    base = a_beats;
    for (int k = 0; k < 50 && a_beats < base + 2; k++) @(posedge clk);
    chk("a_two_beats", 32'(a_beats - base >= 2), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("a_async_clear", 32'({a_busy, a_done, a_err, a_valid, a_last, a_rd_addr, a_mdata, a_maddr}), 32'd0);
    qa.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (a_valid || a_busy) saw = 1'b1;
    end
    chk("a_quiet_after_rst", 32'(saw), 32'd0);
    start_a(0, 2, 1'b1);
    wait_done(1'b0, 30, "a_post_rst_done");
    chk("a_post_rst_drained", 32'(qa.size()), 32'd0);

    // DUT B: non power-of-two depth, zero read latency
    start_b(10, 3, 1'b1);
    @(negedge clk);
    chk("b_lat_c1", 32'({b_valid, b_rd_addr}), 32'({1'b0, 4'd10}));
    @(negedge clk);
    chk("b_lat_c2_valid", 32'(b_valid), 32'd1);
    wait_done(1'b1, 30, "b_wrap_done");
    chk("b_wrap_drained", 32'(qb.size()), 32'd0);

    start_b(12, 1, 1'b0);
    @(negedge clk);
    chk("b_addr12_err", 32'({b_err, b_busy}), 32'b10);
    start_b(3, 13, 1'b0);
    @(negedge clk);
    chk("b_cnt13_err", 32'({b_err, b_busy}), 32'b10);

    start_b(11, 12, 1'b1);
    wait_done(1'b1, 40, "b_full_done");

    repeat (3) @(negedge clk);
    chk("a_final_q", 32'(qa.size()), 32'd0);
    chk("b_final_q", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
